// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the radix-2 Booth controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    localparam int N_DEFAULT = 3;

    // Booth pair {q0, q-1} encodings that require an arithmetic operation
    localparam logic [1:0] Q_ADD = 2'b01;
    localparam logic [1:0] Q_SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_OP    = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/iter_counter.sv
// ============================================================================
// Module      : iter_counter
// Description : Booth iteration counter; clear on load, step on shift,
//               flags the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_counter
    import booth_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign count = r_count;
    assign last  = (r_count == CW'(N - 1));

endmodule

`default_nettype wire

// File: rtl/booth_control.sv
// ============================================================================
// Module      : booth_control
// Description : FSM sequencing the radix-2 Booth multiply datapath.
//               Optional macro BOOTH_SKIP_NOP_EN skips OP for q = 00/11.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_control
    import booth_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [1:0]    q,
    output logic          busy,
    output logic          done,
    output logic          start,
    output logic          suma,
    output logic          resta,
    output logic          desp,
    output logic [CW-1:0] iter
);

    state_t r_state;
    state_t w_next;
    logic   w_last;

    iter_counter #(
        .N  (N),
        .CW (CW)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (desp),
        .count (iter),
        .last  (w_last)
    );

`ifdef BOOTH_SKIP_NOP_EN
    // Pairs 00/11 need no arithmetic, so the FSM can go straight to SHIFT
    logic w_nop;
    assign w_nop = (q[1] == q[0]);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        start  = 1'b0;
        suma   = 1'b0;
        resta  = 1'b0;
        desp   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (go) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                start = 1'b1;
`ifdef BOOTH_SKIP_NOP_EN
                w_next = w_nop ? ST_SHIFT : ST_OP;
`else
                w_next = ST_OP;
`endif
            end
            ST_OP: begin
                case (q)
                    Q_SUB: begin
                        suma  = 1'b1;
                        resta = 1'b1;
                    end
                    Q_ADD: begin
                        suma  = 1'b1;
                    end
                    default: begin
                        suma  = 1'b0;
                    end
                endcase
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                desp = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
`ifdef BOOTH_SKIP_NOP_EN
                    w_next = w_nop ? ST_SHIFT : ST_OP;
`else
                    w_next = ST_OP;
`endif
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_control.sv
// ============================================================================
// Module      : tb_booth_control
// Description : Scoreboard bench for booth_control with a behavioural datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_control;

    localparam int N  = 3;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [1:0]    q;
    logic          busy, done, start, suma, resta, desp;
    logic [CW-1:0] iter;

    always #5 clk = ~clk;

    booth_control #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .start (start),
        .suma  (suma),
        .resta (resta),
        .desp  (desp),
        .iter  (iter)
    );

    // Behavioural Booth datapath driven by the controller's commands
    logic [N-1:0]   mplier = '0;
    logic [N-1:0]   mcand  = '0;
    logic [N:0]     a_reg  = '0;
    logic [N:0]     q_reg  = '0;
    logic [N:0]     m_reg  = '0;
    logic [2*N-1:0] resultado;

    always @(posedge clk) begin
        if (start) begin
            a_reg <= '0;
            q_reg <= {mplier, 1'b0};
            m_reg <= {mcand[N-1], mcand};
        end else if (suma) begin
            a_reg <= resta ? a_reg - m_reg : a_reg + m_reg;
        end else if (desp) begin
            {a_reg, q_reg} <= {a_reg[N], a_reg, q_reg[N:1]};
        end
    end

    assign q         = q_reg[1:0];
    assign resultado = {a_reg[N-1:0], q_reg[N:1]};

    typedef struct packed {
        logic [CW-1:0] it;
        logic          su;
        logic          re;
    } op_t;

    typedef struct packed {
        int             base;
        int             cyc;
        logic [2*N-1:0] res;
    } done_t;

    op_t   op_q[$];
    done_t done_q[$];
    int    start_q[$];

    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;
    logic mon_en   = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge clk) begin
        if (mon_en) begin
            if (start || suma || desp)
                chk("cmd_exclusive", int'(start) + int'(suma) + int'(desp), 1);
            if (start) begin
                chk("start_expected", int'(start_q.size() != 0), 1);
                if (start_q.size() != 0) chk("start_edge", edge_cnt, start_q.pop_front());
            end
            if (busy && !start && !desp && !done) begin
                chk("op_expected", int'(op_q.size() != 0), 1);
                if (op_q.size() != 0) begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("op_suma", int'(suma), int'(o.su));
                    chk("op_resta", int'(resta), int'(o.re));
                    chk("op_iter", int'(iter), int'(o.it));
                end
            end
            if (done) begin
                chk("done_expected", int'(done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", edge_cnt - d.base + 1, d.cyc);
                    chk("resultado", int'(resultado), int'(d.res));
                    chk("done_iter", int'(iter), N);
                    chk("done_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ops holds (suma,resta) pairs, first OP in the top bits
    task automatic push_ops(input logic [2*N-1:0] ops, input int count);
        for (int i = 0; i < count; i++)
            op_q.push_back('{it: CW'(i), su: ops[2*N-1-2*i], re: ops[2*N-2-2*i]});
    endtask

    task automatic push_done(input int base, input int cyc, input logic [2*N-1:0] res);
        done_q.push_back('{base: base, cyc: cyc, res: res});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((done_q.size() != 0 || busy) && n < 60) begin
            tick(1);
            n++;
        end
        chk({name, "_timeout"}, int'(n < 60), 1);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_start"}, int'(start), 0);
        chk({name, "_suma"}, int'(suma), 0);
        chk({name, "_resta"}, int'(resta), 0);
        chk({name, "_desp"}, int'(desp), 0);
        chk({name, "_iter"}, int'(iter), 0);
    endtask

    // One complete multiply with go pulsed for a single cycle
    task automatic run_mul(input string name, input logic [N-1:0] mp, input logic [N-1:0] mc,
                           input logic [2*N-1:0] ops, input logic [2*N-1:0] res);
        int g;
        mplier = mp;
        mcand  = mc;
        go     = 1'b1;
        g      = edge_cnt + 1;
        start_q.push_back(g);
        push_ops(ops, N);
        push_done(g, 2 * N + 2, res);
        tick(1);
        go = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        int g;
        reset = 1'b1;
        go    = 1'b0;
        tick(2);
        reset  = 1'b0;
        mon_en = 1'b1;
        check_quiet("reset");

        // 3 x 2 = 6 ; -4 x 3 = -12
        run_mul("mul_3x2", 3'b011, 3'b010, 6'b11_00_10, 6'b000110);
        run_mul("mul_m4x3", 3'b100, 3'b011, 6'b00_00_11, 6'b110100);

        // go pulsed in cycles 3 and 5 while busy; 1 x 3 = 3
        mplier = 3'b001;
        mcand  = 3'b011;
        go     = 1'b1;
        g      = edge_cnt + 1;
        start_q.push_back(g);
        push_ops(6'b11_10_00, N);
        push_done(g, 8, 6'b000011);
        tick(1); go = 1'b0;
        tick(2); go = 1'b1;
        tick(1); go = 1'b0;
        tick(1); go = 1'b1;
        tick(1); go = 1'b0;
        wait_idle("busy_go");
        tick(3);
        chk("busy_go_idle", int'(busy), 0);

        // go held high: back-to-back multiplies
        mplier = 3'b011;
        mcand  = 3'b010;
        go     = 1'b1;
        g      = edge_cnt + 1;
        start_q.push_back(g);
        start_q.push_back(g + 9);
        push_ops(6'b11_00_10, N);
        push_ops(6'b11_00_10, N);
        push_done(g, 8, 6'b000110);
        push_done(g, 17, 6'b000110);
        tick(10);
        go = 1'b0;
        wait_idle("go_held");

        // Reset during the second SHIFT abandons the multiply
        mplier = 3'b011;
        mcand  = 3'b010;
        go     = 1'b1;
        g      = edge_cnt + 1;
        start_q.push_back(g);
        push_ops(6'b11_00_10, 2);
        tick(1); go = 1'b0;
        tick(4);
        chk("mid_reset_in_shift", int'(desp), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_quiet("mid_reset");
        tick(10);
        run_mul("after_reset", 3'b100, 3'b011, 6'b00_00_11, 6'b110100);

        tick(3);
        chk("leftover_start", start_q.size(), 0);
        chk("leftover_op", op_q.size(), 0);
        chk("leftover_done", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
